// File: rtl/cache_assoc.sv
// Set-associative (1 or 2 way) write-back, write-allocate cache with LRU
// replacement and hit/miss counters, fronting a 128-bit block memory.
module cache_assoc #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  output logic [31:0]  miss_count,
  output logic [31:0]  hit_count
);

  localparam int IDX = $clog2(SETS);
  localparam int TW  = 28 - IDX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd1;
  localparam logic [1:0] ST_ALLOC = 2'd2;

  function automatic logic [31:0] get_word(input logic [127:0] line, input logic [1:0] w);
    return line[{w, 5'd0} +: 32];
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] w,
                                            input logic [31:0] d);
    logic [127:0] r;
    r = line;
    r[{w, 5'd0} +: 32] = d;
    return r;
  endfunction

  // Storage is always two ways deep; way 1 simply never fills when WAYS=1.
  logic [1:0]     state_r;
  logic [SETS-1:0] valid_r [2];
  logic [SETS-1:0] dirty_r [2];
  logic [SETS-1:0] lru_r;
  logic [TW-1:0]  tag_r  [2][SETS];
  logic [127:0]   line_r [2][SETS];
  logic           victim_r;

  logic           req_s;
  logic [IDX-1:0] index_s;
  logic [TW-1:0]  tag_s;
  logic [1:0]     word_s;
  logic [1:0]     way_hit_s;
  logic           hit_s;
  logic           hit_way_s;
  logic           victim_s;

  assign req_s   = proc_read | proc_write;
  assign index_s = proc_addr[IDX+1:2];
  assign tag_s   = proc_addr[29:IDX+2];
  assign word_s  = proc_addr[1:0];

  // Tag lookup and victim choice: first invalid way, else the LRU way.
  always_comb begin
    way_hit_s[0] = valid_r[0][index_s] && (tag_r[0][index_s] == tag_s);
    way_hit_s[1] = (WAYS == 2) && valid_r[1][index_s] && (tag_r[1][index_s] == tag_s);
    hit_s        = req_s && (state_r == ST_IDLE) && (|way_hit_s);
    hit_way_s    = way_hit_s[1];
    if (WAYS == 1) begin
      victim_s = 1'b0;
    end else if (!valid_r[0][index_s]) begin
      victim_s = 1'b0;
    end else if (!valid_r[1][index_s]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r[index_s];
    end
  end

  assign proc_stall = req_s & ~hit_s;
  assign proc_rdata = (hit_s && proc_read) ? get_word(line_r[hit_way_s][index_s], word_s) : 32'd0;

  // Control FSM, line state bits, memory handshake and counters.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_r    <= ST_IDLE;
      valid_r[0] <= '0;
      valid_r[1] <= '0;
      dirty_r[0] <= '0;
      dirty_r[1] <= '0;
      lru_r      <= '0;
      victim_r   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 28'd0;
      mem_wdata  <= 128'd0;
      miss_count <= 32'd0;
      hit_count  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            hit_count             <= hit_count + 32'd1;
            lru_r[index_s]        <= ~hit_way_s;
            if (proc_write) begin
              dirty_r[hit_way_s][index_s] <= 1'b1;
            end
          end else if (req_s) begin
            miss_count <= miss_count + 32'd1;
            victim_r   <= victim_s;
            if (valid_r[victim_s][index_s] && dirty_r[victim_s][index_s]) begin
              state_r   <= ST_WB;
              mem_write <= 1'b1;
              mem_addr  <= {tag_r[victim_s][index_s], index_s};
              mem_wdata <= line_r[victim_s][index_s];
            end else begin
              state_r  <= ST_ALLOC;
              mem_read <= 1'b1;
              mem_addr <= proc_addr[29:2];
            end
          end
        end
        ST_WB: begin
          if (mem_ready) begin
            state_r   <= ST_ALLOC;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= proc_addr[29:2];
          end
        end
        ST_ALLOC: begin
          if (mem_ready) begin
            state_r                    <= ST_IDLE;
            mem_read                   <= 1'b0;
            valid_r[victim_r][index_s] <= 1'b1;
            dirty_r[victim_r][index_s] <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Line data and tags: write-hit merge and block fill; validity gates their use.
  always_ff @(posedge clk) begin
    if (hit_s && proc_write) begin
      line_r[hit_way_s][index_s] <= put_word(line_r[hit_way_s][index_s], word_s, proc_wdata);
    end else if ((state_r == ST_ALLOC) && mem_ready) begin
      line_r[victim_r][index_s] <= mem_rdata;
      tag_r[victim_r][index_s]  <= tag_s;
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed scoreboard bench for cache_assoc (SETS=8, WAYS=2) with a
// latency-2 block memory model whose word i starts at value i.
module tb_cache_assoc;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata = 128'd0;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [31:0]  miss_count, hit_count;

  always #5 clk = ~clk;

  cache_assoc #(.SETS(8), .WAYS(2)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
    .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .miss_count(miss_count), .hit_count(hit_count)
  );

  logic [31:0] mem_words [0:4095];
  logic [31:0] ref_mem   [0:4095];
  logic [31:0] sb [$];
  int total = 0;
  int bad   = 0;

  logic        resp_en      = 1'b1;
  logic        manual_ready = 1'b0;
  logic        auto_ready   = 1'b0;
  int          lat = 0, ev_seq = 0;
  int          rd_count = 0, wb_count = 0, last_rd_seq = 0, last_wb_seq = 0;
  logic [27:0] last_rd_addr = 28'd0, last_wb_addr = 28'd0;
  logic [31:0] last_wb_data = 32'd0;

  assign mem_ready = auto_ready | manual_ready;

  // Block memory: answers a fetch or write-back two cycles after it appears.
  always @(negedge clk) begin
    int base;
    auto_ready = 1'b0;
    base = int'(mem_addr[9:0]) * 4;
    if (!proc_reset_n) begin
      for (int i = 0; i < 4096; i++) mem_words[i] = i;
      lat = 0; rd_count = 0; wb_count = 0;
    end else if (resp_en && (mem_read || mem_write)) begin
      lat++;
      if (lat == 2) begin
        lat = 0;
        ev_seq++;
        auto_ready = 1'b1;
        if (mem_write) begin
          for (int w = 0; w < 4; w++) mem_words[base + w] = mem_wdata[32*w +: 32];
          wb_count++; last_wb_seq = ev_seq; last_wb_addr = mem_addr;
          last_wb_data = mem_wdata[31:0];
        end else begin
          mem_rdata = {mem_words[base + 3], mem_words[base + 2], mem_words[base + 1], mem_words[base]};
          rd_count++; last_rd_seq = ev_seq; last_rd_addr = mem_addr;
        end
      end
    end else begin
      lat = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 4096; i++) ref_mem[i] = i;
    sb.delete();
  endtask

  task automatic do_reset();
    proc_read = 1'b0; proc_write = 1'b0;
    proc_reset_n = 1'b0;
    init_ref();
    repeat (2) @(negedge clk);
    #1 proc_reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One processor access started at a negedge; returns cycles spent stalled.
  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] d, output int stall_cyc);
    int cyc;
    logic [31:0] exp;
    cyc = 0;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
    if (wr) ref_mem[a[11:0]] = d;
    else if (rd) sb.push_back(ref_mem[a[11:0]]);
    #1;
    while (proc_stall && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    stall_cyc = cyc;
    if (proc_stall) begin
      total++; bad++;
      $error("FAIL timeout: addr=%0h still stalled after %0d cycles, required completion", a, cyc);
      if (rd && !wr) void'(sb.pop_front());
    end else if (rd && !wr) begin
      exp = sb.pop_front();
      check("rdata", proc_rdata, exp);
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s;
    int cyc;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = 30'd0; proc_wdata = 32'd0;
    proc_reset_n = 1'b0;
    do_reset();

    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", {4'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata_lo", mem_wdata[31:0], 32'd0);
    check("rst_miss", miss_count, 32'd0);
    check("rst_hit", hit_count, 32'd0);
    check("rst_stall", {31'd0, proc_stall}, 32'd0);
    check("rst_rdata", proc_rdata, 32'd0);

    // Words 0..3: one clean miss, then same-block hits.
    access(1'b1, 1'b0, 30'd0, 32'd0, s);
    check("w0_stalled", {31'd0, (s > 0)}, 32'd1);
    check("w0_fetch_count", rd_count, 32'd1);
    check("w0_fetch_addr", {4'd0, last_rd_addr}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      access(1'b1, 1'b0, 30'(k), 32'd0, s);
      check("hit_stall", s, 32'd0);
    end
    check("t1_miss", miss_count, 32'd1);
    check("t1_hit", hit_count, 32'd4);

    // Set-0 conflict: 64 evicts LRU block 0, so the final read of 0 refetches.
    access(1'b1, 1'b0, 30'd0, 32'd0, s);
    access(1'b1, 1'b0, 30'd32, 32'd0, s);
    access(1'b1, 1'b0, 30'd64, 32'd0, s);
    access(1'b1, 1'b0, 30'd0, 32'd0, s);
    check("conf_refetch_stall", {31'd0, (s > 0)}, 32'd1);
    check("conf_miss", miss_count, 32'd4);
    check("conf_hit", hit_count, 32'd8);
    check("conf_no_wb", wb_count, 32'd0);
    check("conf_fetch_count", rd_count, 32'd4);
    check("conf_last_fetch", {4'd0, last_rd_addr}, 32'd0);

    // Dirty write-back of block 0 before the fill of block 16.
    do_reset();
    access(1'b0, 1'b1, 30'd0, 32'd1, s);
    check("dw_write_missed", {31'd0, (s > 0)}, 32'd1);
    access(1'b1, 1'b0, 30'd32, 32'd0, s);
    access(1'b1, 1'b0, 30'd64, 32'd0, s);
    check("dw_wb_count", wb_count, 32'd1);
    check("dw_wb_addr", {4'd0, last_wb_addr}, 32'd0);
    check("dw_wb_data", last_wb_data, 32'd1);
    check("dw_fill_addr", {4'd0, last_rd_addr}, 32'd16);
    check("dw_wb_first", {31'd0, (last_wb_seq < last_rd_seq)}, 32'd1);
    check("dw_hits", hit_count, 32'd3);
    access(1'b1, 1'b0, 30'd0, 32'd0, s);

    // Simultaneous read and write is a write.
    access(1'b1, 1'b1, 30'd5, 32'hA, s);
    access(1'b1, 1'b0, 30'd5, 32'd0, s);

    // Reset while a fill is outstanding.
    do_reset();
    resp_en = 1'b0;
    proc_read = 1'b1; proc_addr = 30'd0;
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    check("ra_fill_pending", {31'd0, mem_read}, 32'd1);
    #2 proc_reset_n = 1'b0;
    #1;
    check("ra_mem_read_drop", {31'd0, mem_read}, 32'd0);
    check("ra_miss_cleared", miss_count, 32'd0);
    proc_read = 1'b0;
    init_ref();
    @(negedge clk);
    #1 proc_reset_n = 1'b1;
    @(negedge clk);
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    #1;
    check("ra_idle_read", {31'd0, mem_read}, 32'd0);
    check("ra_idle_write", {31'd0, mem_write}, 32'd0);
    check("ra_idle_stall", {31'd0, proc_stall}, 32'd0);
    resp_en = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 30'd0, 32'd0, s);
    check("ra_refetch_stall", {31'd0, (s > 0)}, 32'd1);
    check("ra_refetch_miss", miss_count, 32'd1);

    // Read-write-read over words 0..1023.
    for (int k = 0; k < 1024; k++) begin
      access(1'b1, 1'b0, 30'(k), 32'd0, s);
      access(1'b0, 1'b1, 30'(k), 32'(k * 3 + 1), s);
      access(1'b1, 1'b0, 30'(k), 32'd0, s);
    end
    check("suite_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
